nibble_serial_adder: RTL and testbench

//   Multi-cycle WIDTH-bit adder that streams operands through one 4-bit ripple-carry adder,
//   one nibble per clock, LSB nibble first, carrying Cout into the next nibble's Cin.
//   It sits directly around the 4-bit adder: it slices and feeds the operands and collects Sum/Cout.

---
 rtl/nibble_add_pkg.sv | 17 +
 rtl/nibble_serial_adder_if.sv | 25 ++
 rtl/nibble_serial_adder_rca4.sv | 27 ++
 rtl/nibble_serial_adder.sv | 100 ++++++++++
 tb/tb_nibble_serial_adder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM encoding
// and a helper that derives the nibble count from the operand width.
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshakes of the nibble-serial adder. The source/sink
// side uses master; the adder itself uses slave.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/nibble_serial_adder_rca4.sv
// The existing 4-bit ripple-carry adder, purely combinational.
module nibble_serial_adder_rca4
    import nibble_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                Cin,
    output logic [NIBBLE_W-1:0] Sum,
    output logic                Cout
);

    logic [NIBBLE_W:0] c;

    // NOTE: the carry chain lives in one always_comb with a default on every
    // output, so no bit can hold its old value and infer a latch.
    always_comb begin
        c    = '0;
        Sum  = '0;
        c[0] = Cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            Sum[i]   = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        Cout = c[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that streams the operands through one 4-bit ripple-carry
// adder, LSB nibble first, one nibble per clock.
module nibble_serial_adder
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    nibble_serial_adder_if.slave bus
);

    localparam int                N     = nibble_count(WIDTH);
    localparam int                CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N - 1);

    state_t              state;
    state_t              next_state;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                carry;
    logic [CNT_W-1:0]    count;
    logic [WIDTH-1:0]    sum_q;
    logic                cout_q;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;

    // {count, 2'b00} is the bit offset of nibble k; its width always spans WIDTH.
    always_comb begin
        nib_a = a_q[{count, 2'b00} +: NIBBLE_W];
        nib_b = b_q[{count, 2'b00} +: NIBBLE_W];
    end

    nibble_serial_adder_rca4 u_rca4 (
        .A    (nib_a),
        .B    (nib_b),
        .Cin  (carry),
        .Sum  (nib_sum),
        .Cout (nib_cout)
    );

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // The illegal encoding 2'd3 falls through to the default and recovers to IDLE.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = bus.in_valid  ? RUN  : IDLE;
            RUN:     next_state = (count == LAST) ? DONE : RUN;
            DONE:    next_state = bus.out_ready ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        carry <= bus.cin;
                        count <= '0;
                    end
                end
                RUN: begin
                    sum_q[{count, 2'b00} +: NIBBLE_W] <= nib_sum;
                    carry <= nib_cout;
                    if (count == LAST) cout_q <= nib_cout;
                    else               count  <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed vector
// table, handshake corner sequences and a randomized scoreboard run.
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(W)) bus ();

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operand set and wait for the result; leaves the bench
    // sampling the first DONE cycle (handshake not yet completed).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output logic [W-1:0] s, output logic co, output int lat);
        int guard = 0;
        while (!bus.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) check("out_valid_timeout", 32'd0, 32'd1);
        s  = bus.sum;
        co = bus.cout;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [8];
        logic [W-1:0] s;
        logic         co;
        int           lat;
        int           low_cnt;
        int           ov_first;
        logic [W-1:0] first_sum;
        logic         first_cout;
        logic [W:0]   exp_q [$];
        logic [W:0]   exp_v;
        logic [W:0]   got_v;
        int           issued;
        int           received;
        int           cyc;
        logic         pending;
        logic         acc;
        logic         rel;

        vecs[0] = '{a: 16'h0000, b: 16'h0000, cin: 1'b0, sum: 16'h0000, cout: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
        vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1};
        vecs[3] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, sum: 16'h5555, cout: 1'b0};
        vecs[4] = '{a: 16'h00FF, b: 16'h0001, cin: 1'b0, sum: 16'h0100, cout: 1'b0};
        vecs[5] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
        vecs[6] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, sum: 16'h8000, cout: 1'b0};
        vecs[7] = '{a: 16'h0F0F, b: 16'h00F1, cin: 1'b1, sum: 16'h1001, cout: 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_in_ready",  32'(bus.in_ready),  32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_sum",       32'(bus.sum),       32'd0);
        check("reset_cout",      32'(bus.cout),      32'd0);

        // Test 1: latency and in_ready profile for one op.
        bus.a = 16'h0000; bus.b = 16'h0000; bus.cin = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        low_cnt  = 0;
        ov_first = -1;
        first_sum  = 'x;
        first_cout = 1'bx;
        for (int i = 0; i < 8; i++) begin
            if (!bus.in_ready) low_cnt++;
            if (bus.out_valid && ov_first < 0) begin
                ov_first   = i;
                first_sum  = bus.sum;
                first_cout = bus.cout;
            end
            tick();
        end
        check("t1_out_valid_cycle", 32'(ov_first),   32'd4);
        check("t1_in_ready_low",    32'(low_cnt),    32'd5);
        check("t1_sum",             32'(first_sum),  32'h0000);
        check("t1_cout",            32'(first_cout), 32'd0);

        // Directed vector table.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, lat);
            check($sformatf("vec%0d_sum", i),  32'(s),   32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(co),  32'(vecs[i].cout));
            check($sformatf("vec%0d_lat", i),  32'(lat), 32'd4);
            tick();
        end

        // Test 3: operands toggle during RUN; captured values must be used.
        bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.cin = 1'($urandom);
            tick();
            lat++;
        end
        check("t3_sum",  32'(bus.sum),  32'h5555);
        check("t3_cout", 32'(bus.cout), 32'd0);
        tick();

        // Test 4: backpressure in DONE, pulsed in_valid must be ignored.
        bus.out_ready = 1'b0;
        run_op(16'h1111, 16'h2222, 1'b0, s, co, lat);
        for (int j = 0; j < 3; j++) begin
            bus.in_valid = (j == 0);
            bus.a = 16'hAAAA; bus.b = 16'h5555; bus.cin = 1'b1;
            check($sformatf("t4_out_valid_%0d", j), 32'(bus.out_valid), 32'd1);
            check($sformatf("t4_in_ready_%0d", j),  32'(bus.in_ready),  32'd0);
            check($sformatf("t4_sum_%0d", j),       32'(bus.sum),       32'h3333);
            check($sformatf("t4_cout_%0d", j),      32'(bus.cout),      32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        check("t4_still_done", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check("t4_idle_in_ready",  32'(bus.in_ready),  32'd1);
        check("t4_idle_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("t4_no_accept", 32'(bus.in_ready), 32'd1);

        // Test 5: reset after nibble 1 aborts the op.
        bus.a = 16'hABCD; bus.b = 16'h1111; bus.cin = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_in_ready",  32'(bus.in_ready),  32'd1);
        check("t5_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_sum",       32'(bus.sum),       32'h0000);
        check("t5_cout",      32'(bus.cout),      32'd0);
        run_op(16'h00FF, 16'h0001, 1'b0, s, co, lat);
        check("t5_after_sum",  32'(s),  32'h0100);
        check("t5_after_cout", 32'(co), 32'd0);
        tick();

        // Test 6: random back-to-back ops with random out_ready stalls.
        issued   = 0;
        received = 0;
        cyc      = 0;
        pending  = 1'b0;
        while (received < 1000 && cyc < 20000) begin
            if (!pending && issued < 1000) begin
                bus.a   = W'($urandom);
                bus.b   = W'($urandom);
                bus.cin = 1'($urandom);
                pending = 1'b1;
            end
            bus.in_valid  = pending;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            acc = bus.in_valid && bus.in_ready;
            rel = bus.out_valid && bus.out_ready;
            if (rel) begin
                got_v = {bus.cout, bus.sum};
                if (exp_q.size() == 0) begin
                    check("t6_extra_result", 32'd1, 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check($sformatf("t6_result_%0d", received), 32'(got_v), 32'(exp_v));
                end
                received++;
            end
            if (acc) begin
                exp_q.push_back({1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin});
                pending = 1'b0;
                issued++;
            end
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("t6_received", 32'(received),     32'd1000);
        check("t6_leftover", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
